// File: rtl/coef_seq_pkg.sv
// Shared types and width helpers for the coefficient sequencer.
package coef_seq_pkg;

  // Shadow-bank load progress: IDLE waits for the first word, LOAD collects
  // the rest, PENDING holds a full shadow bank until the frame boundary.
  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_LOAD    = 2'd1,
    LD_PENDING = 2'd2
  } load_state_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/coef_seq_bank_coef_bank.sv
// One LANES x TM coefficient register bank: lane-major linear write port,
// per-lane combinational read at a shared slot index.
module coef_bank
  import coef_seq_pkg::*;
#(
  parameter int COEFW = 18,
  parameter int TM    = 4,
  parameter int LANES = 2,
  parameter int CW    = width_of(TM),
  parameter int IW    = width_of(TM * LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IW-1:0]           widx,
  input  logic signed [COEFW-1:0] wdata,
  input  logic [CW-1:0]           rd_slot,
  output logic signed [COEFW-1:0] rd_data [LANES]
);

  logic signed [COEFW-1:0] mem [LANES][TM];

  // Write word widx to lane widx/TM, slot widx%TM; reset clears the bank.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < TM; s++) begin
        if (rst) begin
          mem[l][s] <= '0;
        end else if (we && (widx == IW'(l * TM + s))) begin
          mem[l][s] <= wdata;
        end
      end
    end
  end

  // Per-lane read mux; slot values outside 0..TM-1 read as zero.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_data[l] = '0;
      for (int s = 0; s < TM; s++) begin
        if (rd_slot == CW'(s)) rd_data[l] = mem[l][s];
      end
    end
  end

endmodule

// File: rtl/coef_seq_bank.sv
// Double-buffered multi-lane coefficient sequencer: slot counter, shadow
// load FSM, frame-boundary bank swap and registered per-lane outputs.
//
// Load handshake: a word transfers on a rising edge where load_valid and
// load_ready are both high. load_ready depends only on the load state (and
// is held low during reset), never on load_valid; load_data must be stable
// while load_valid is high. A stalled load simply waits at its index.
module coef_seq_bank
  import coef_seq_pkg::*;
#(
  parameter int COEFW = 18,
  parameter int TM    = 4,
  parameter int LANES = 2,
  parameter int CW    = width_of(TM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [CW-1:0]           counter_out,
  output logic                    frame_start,
  output logic signed [COEFW-1:0] coef_out [LANES],
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic signed [COEFW-1:0] load_data,
  output logic                    swap_pending,
  output logic                    swap_done,
  output load_state_t             dbg_state
);

  localparam int NW = TM * LANES;
  localparam int IW = width_of(NW);
  localparam logic [CW-1:0] CNT_LAST = CW'(TM - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);

  logic [CW-1:0]           cnt;
  logic                    bank_sel;   // selects the active bank
  load_state_t             state, state_nx;
  logic [IW-1:0]           load_idx, load_idx_nx;
  logic                    accept, swap, at_boundary;
  logic                    we0, we1;
  logic signed [COEFW-1:0] rd0 [LANES];
  logic signed [COEFW-1:0] rd1 [LANES];

  assign load_ready   = !rst && (state != LD_PENDING);
  assign accept       = load_valid && load_ready;
  assign swap_pending = (state == LD_PENDING);
  assign dbg_state    = state;
  // Enabled: swap on the wrap edge. Stalled: swap only while parked at slot 0.
  assign at_boundary  = en ? (cnt == CNT_LAST) : (cnt == '0);
  // Loads always target the shadow bank, i.e. the one not selected.
  assign we0 = accept && bank_sel;
  assign we1 = accept && !bank_sel;

  coef_bank #(.COEFW(COEFW), .TM(TM), .LANES(LANES), .CW(CW), .IW(IW)) u_bank0 (
    .clk(clk), .rst(rst), .we(we0), .widx(load_idx), .wdata(load_data),
    .rd_slot(cnt), .rd_data(rd0)
  );

  coef_bank #(.COEFW(COEFW), .TM(TM), .LANES(LANES), .CW(CW), .IW(IW)) u_bank1 (
    .clk(clk), .rst(rst), .we(we1), .widx(load_idx), .wdata(load_data),
    .rd_slot(cnt), .rd_data(rd1)
  );

  // Slot counter: wraps at TM-1, holds when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Load FSM next-state: count words lane-major, then wait for the boundary.
  always_comb begin
    state_nx    = state;
    load_idx_nx = load_idx;
    swap        = 1'b0;
    case (state)
      LD_IDLE, LD_LOAD: begin
        if (accept) begin
          if (load_idx == IDX_LAST) begin
            state_nx = LD_PENDING;
          end else begin
            state_nx    = LD_LOAD;
            load_idx_nx = load_idx + 1'b1;
          end
        end
      end
      LD_PENDING: begin
        if (at_boundary) begin
          swap        = 1'b1;
          state_nx    = LD_IDLE;
          load_idx_nx = '0;
        end
      end
      default: state_nx = LD_IDLE;
    endcase
  end

  // Load FSM state, bank select and swap pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LD_IDLE;
      load_idx  <= '0;
      bank_sel  <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      state     <= state_nx;
      load_idx  <= load_idx_nx;
      swap_done <= swap;
      if (swap) bank_sel <= ~bank_sel;
    end
  end

  // Output register: slot index, frame marker and active-bank coefficients
  // all sampled from the same cnt so they stay mutually consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= '0;
      frame_start <= 1'b0;
      for (int l = 0; l < LANES; l++) coef_out[l] <= '0;
    end else begin
      counter_out <= cnt;
      frame_start <= en && (cnt == '0);
      for (int l = 0; l < LANES; l++) coef_out[l] <= bank_sel ? rd1[l] : rd0[l];
    end
  end

endmodule

// File: tb/tb_coef_seq_bank.sv
// Bench for coef_seq_bank: three configurations (TM=4/LANES=2, TM=1/LANES=3,
// TM=3/LANES=2) driven in lockstep and compared each cycle against a
// word-queue reference model.
module tb_coef_seq_bank;
  import coef_seq_pkg::*;

  localparam int COEFW = 18;

  // clock / reset
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic             rst, en;
  logic             vld [3];
  logic [COEFW-1:0] dat [3];

  logic [1:0]              cnt_a, cnt_c;
  logic [0:0]              cnt_b;
  logic signed [COEFW-1:0] coef_a [2];
  logic signed [COEFW-1:0] coef_b [3];
  logic signed [COEFW-1:0] coef_c [2];
  logic                    fs_o [3], rdy_o [3], pend_o [3], sd_o [3];
  load_state_t             st_o [3];

  coef_seq_bank #(.COEFW(COEFW), .TM(4), .LANES(2)) u_a (
    .clk(clk), .rst(rst), .en(en), .counter_out(cnt_a), .frame_start(fs_o[0]),
    .coef_out(coef_a), .load_valid(vld[0]), .load_ready(rdy_o[0]),
    .load_data(dat[0]), .swap_pending(pend_o[0]), .swap_done(sd_o[0]),
    .dbg_state(st_o[0]));

  coef_seq_bank #(.COEFW(COEFW), .TM(1), .LANES(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .counter_out(cnt_b), .frame_start(fs_o[1]),
    .coef_out(coef_b), .load_valid(vld[1]), .load_ready(rdy_o[1]),
    .load_data(dat[1]), .swap_pending(pend_o[1]), .swap_done(sd_o[1]),
    .dbg_state(st_o[1]));

  coef_seq_bank #(.COEFW(COEFW), .TM(3), .LANES(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .counter_out(cnt_c), .frame_start(fs_o[2]),
    .coef_out(coef_c), .load_valid(vld[2]), .load_ready(rdy_o[2]),
    .load_data(dat[2]), .swap_pending(pend_o[2]), .swap_done(sd_o[2]),
    .dbg_state(st_o[2]));

  // Observed outputs gathered into uniform arrays.
  logic [1:0]       obs_cnt  [3];
  logic [COEFW-1:0] obs_coef [3][3];
  always_comb begin
    for (int d = 0; d < 3; d++)
      for (int l = 0; l < 3; l++) obs_coef[d][l] = '0;
    obs_cnt[0] = cnt_a;
    obs_cnt[1] = {1'b0, cnt_b};
    obs_cnt[2] = cnt_c;
    obs_coef[0][0] = coef_a[0];
    obs_coef[0][1] = coef_a[1];
    obs_coef[1][0] = coef_b[0];
    obs_coef[1][1] = coef_b[1];
    obs_coef[1][2] = coef_b[2];
    obs_coef[2][0] = coef_c[0];
    obs_coef[2][1] = coef_c[1];
  end

  // reference model: active coefficient table plus queue of shadow words
  int               tm_v [3] = '{4, 1, 3};
  int               ln_v [3] = '{2, 3, 2};
  int               m_cnt [3];
  logic [COEFW-1:0] m_act [3][3][4];
  logic [COEFW-1:0] exp_q [3][$];
  int               m_out_cnt [3];
  logic [COEFW-1:0] m_out_coef [3][3];
  logic             m_fs [3], m_sd [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int  tm, n;
      bit  pend, sw;
      tm = tm_v[d];
      n  = tm * ln_v[d];
      if (rst) begin
        m_cnt[d] = 0;
        for (int l = 0; l < 3; l++)
          for (int s = 0; s < 4; s++) m_act[d][l][s] = '0;
        exp_q[d].delete();
        m_out_cnt[d] = 0;
        for (int l = 0; l < 3; l++) m_out_coef[d][l] = '0;
        m_fs[d] = 1'b0;
        m_sd[d] = 1'b0;
      end else begin
        m_out_cnt[d] = m_cnt[d];
        for (int l = 0; l < ln_v[d]; l++) m_out_coef[d][l] = m_act[d][l][m_cnt[d]];
        m_fs[d] = en && (m_cnt[d] == 0);
        pend = (exp_q[d].size() == n);
        sw = pend && ((en && m_cnt[d] == tm - 1) || (!en && m_cnt[d] == 0));
        if (!pend && vld[d]) exp_q[d].push_back(dat[d]);
        if (sw) begin
          for (int k = 0; k < n; k++) m_act[d][k / tm][k % tm] = exp_q[d][k];
          exp_q[d].delete();
        end
        m_sd[d] = sw;
        if (en) m_cnt[d] = (m_cnt[d] == tm - 1) ? 0 : m_cnt[d] + 1;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      bit pend;
      pend = (exp_q[d].size() == tm_v[d] * ln_v[d]);
      check($sformatf("d%0d counter_out", d), 32'(obs_cnt[d]), 32'(m_out_cnt[d]));
      check($sformatf("d%0d frame_start", d), 32'(fs_o[d]), 32'(m_fs[d]));
      check($sformatf("d%0d swap_done", d), 32'(sd_o[d]), 32'(m_sd[d]));
      check($sformatf("d%0d swap_pending", d), 32'(pend_o[d]), 32'(pend));
      check($sformatf("d%0d load_ready", d), 32'(rdy_o[d]), 32'(!rst && !pend));
      for (int l = 0; l < ln_v[d]; l++)
        check($sformatf("d%0d coef_out[%0d]", d, l), 32'(obs_coef[d][l]), 32'(m_out_coef[d][l]));
    end
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_loads();
    for (int d = 0; d < 3; d++) vld[d] = 1'b0;
  endtask

  task automatic run_to_cnt0(input int target);
    int b = 16;
    while (m_cnt[0] != target && b > 0) begin
      tick();
      b--;
    end
  endtask

  task automatic wait_swap_a(input int budget, input string tag);
    int b = budget;
    do begin
      tick();
      b--;
    end while (sd_o[0] !== 1'b1 && b > 0);
    checks++;
    assert (sd_o[0] === 1'b1) else begin
      errors++;
      $error("FAIL %s swap_done timeout observed=%0b expected=1", tag, sd_o[0]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0;
      dat[d] = '0;
    end
    tick();
    tick();

    // free-running frames with empty banks
    rst = 1'b0;
    en  = 1'b1;
    repeat (12) tick();

    // back-to-back loads; C and B start with the most-negative value
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < 3; d++) vld[d] = (i < tm_v[d] * ln_v[d]);
      dat[0] = COEFW'(i + 1);
      dat[1] = (i == 0) ? 18'h20000 : COEFW'(i + 1);
      dat[2] = (i == 0) ? 18'h20000 : COEFW'(i * 7 + 3);
      tick();
    end
    idle_loads();
    wait_swap_a(20, "b2b");
    repeat (6) tick();

    // valid toggling every other cycle mid-frame
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 3; d++) vld[d] = i[0];
      for (int d = 0; d < 3; d++) dat[d] = COEFW'(100 + i);
      tick();
    end
    idle_loads();
    wait_swap_a(20, "toggle");
    repeat (4) tick();

    // stalled at slot 2 while pending: no swap until enable resumes and wraps
    run_to_cnt0(2);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vld[0] = 1'b1;
      dat[0] = COEFW'(200 + i);
      tick();
    end
    idle_loads();
    repeat (4) tick();
    en = 1'b1;
    wait_swap_a(10, "resume");
    repeat (4) tick();

    // stalled at slot 0 while pending: swap without enable
    run_to_cnt0(0);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vld[0] = 1'b1;
      dat[0] = COEFW'(300 + i);
      tick();
    end
    idle_loads();
    wait_swap_a(4, "stall0");
    en = 1'b1;
    repeat (8) tick();

    // reset after 5 of 8 words, then a fresh negative load
    for (int i = 0; i < 5; i++) begin
      vld[0] = 1'b1;
      dat[0] = COEFW'(400 + i);
      tick();
    end
    vld[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vld[0] = 1'b1;
      dat[0] = COEFW'(-(i + 1));
      tick();
    end
    idle_loads();
    wait_swap_a(20, "post_rst");
    repeat (8) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 3; d++) begin
        vld[d] = ($urandom_range(0, 1) == 1);
        dat[d] = COEFW'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    idle_loads();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coef_seq_bank.md
# coef_seq_bank

Double-buffered, multi-lane coefficient sequencer for the time-multiplexed FIR datapath; the next generation of the single-bank coefficient multiplexer. Holds an active and a shadow coefficient bank, generates the TM-slot multiplex counter internally, and drives LANES parallel DSP chains with per-slot coefficients. New coefficient sets stream into the shadow bank over a valid/ready port and swap in atomically at a frame boundary, so no frame ever mixes old and new coefficients.

## Interface
- COEFW, 18: coefficient width, signed.
- TM, 4: time-multiplex factor (slots per frame), ≥1, need not be a power of 2.
- LANES, 2: parallel DSP chains fed per slot, ≥1.
- CW, max(1,$clog2(TM)): slot counter width.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  advance slot counter this cycle.
- counter_out  out  CW  registered slot index matching coef_out.
- frame_start  out  1  registered; high when counter_out==0 was produced by an enabled cycle.
- coef_out  out  LANES×COEFW signed (unpacked [LANES])  registered active-bank coefficient per lane.
- load_valid  in  1  load word offered.
- load_ready  out  1  load word can be accepted.
- load_data  in  COEFW signed  coefficient word.
- swap_pending  out  1  shadow bank full, waiting for frame boundary.
- swap_done  out  1  one-cycle pulse, cycle after bank swap.

## Operation
- Slot counter cnt: when en, cnt <= (cnt==TM-1) ? 0 : cnt+1; holds when !en. TM=1: cnt stays 0.
- Output register every cycle: counter_out <= cnt; coef_out[l] <= active[l][cnt]; frame_start <= en && cnt==0.
- Load FSM states: IDLE, LOAD, PENDING.
  - IDLE: load_ready=1; accepted word (valid&&ready) written to shadow index 0 -> LOAD (or PENDING if TM*LANES==1).
  - LOAD: load_ready=1; word k written to shadow[lane=k/TM][slot=k%TM], k = 0..TM*LANES-1 lane-major; after word TM*LANES-1 -> PENDING.
  - PENDING: load_ready=0, swap_pending=1. Swap when (en && cnt==TM-1) or (!en && cnt==0): bank select toggles, load index clears -> IDLE; swap_done=1 next cycle.
- Swap makes shadow active; previous active becomes shadow and is overwritten by next load.
- No partial-load abort other than rst; a stalled load (valid low) holds index indefinitely.

## Timing
- Output latency: 1 cycle from cnt to counter_out/coef_out/frame_start; the three are always mutually consistent.
- Swap edge at cnt wrap: first output with counter_out==0 after swap uses the new bank; all slots of every frame come from one bank.
- Load: one word per cycle max; load_ready combinational from state only (no dependency on load_valid).
- Last word accepted at edge N: swap_pending=1 from cycle N+1; earliest swap at edge N+1 if boundary condition holds then.
- Reset: cnt=0, bank select=0, both banks all zero, state IDLE, load index 0, counter_out=0, coef_out all 0, frame_start=0, swap_pending=0, swap_done=0, load_ready=0 while rst high, 1 first cycle after.
- rst mid-load or while PENDING: shadow contents and load progress discarded, banks cleared.
- Arithmetic: coefficients passed through unmodified, no sign extension or rounding; index math uses unsigned widths of $clog2(TM*LANES).

## Structure
- Package coef_seq_pkg: load FSM state enum typedef, helper for CW/index width computation.
- Sub-module coef_bank: one LANES×TM register bank with write port (index, data, we) and per-lane read at slot; instantiated twice, selected by bank select bit.
- Top holds counter, FSM, output registers.

## Test plan
- Reset then en=1 for 12 cycles, TM=4, LANES=2: counter_out 0,1,2,3,0…, frame_start every 4th cycle, coef_out all 0.
- Load words 1..8 back-to-back, en=1: swap_pending rises after 8th word, swap on next cnt 3->0 edge; following frame coef_out[0]=1,2,3,4, coef_out[1]=5,6,7,8; swap_done single pulse.
- Load during mid-frame with load_valid toggling every other cycle: previous frame outputs unchanged, no mixed frame, load_ready low throughout PENDING.
- en=0 with cnt==2 while PENDING: no swap until en resumes and cnt wraps; then en=0 at cnt==0 with PENDING: swap occurs without enable.
- rst asserted after 5 of 8 load words: after rst, fresh 8-word load (values -1..-8) appears correctly, no residue of aborted words.
- TM=1, LANES=3 and TM=3 (non-power-of-2): counter wraps at TM-1, 3-word load swaps at next enabled cycle, coef values exact incl. most-negative COEFW value.
